// File: rtl/adsr_envelope.sv
// ADSR envelope generator and amplitude modulator for a single voice.
// The envelope advances once per sample strobe (in_ready). Gate rises seen
// between strobes are held in a sticky flag and applied at the next strobe,
// before that strobe's rate step.
// Optional feature: define ADSR_VELOCITY_EN to add a 7-bit velocity port. It
// scales the attack peak and the sustain target. Velocity 127 is full scale.
module adsr_envelope #(
  parameter int SAMPLE_W = 16,
  parameter int ENV_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       gate,
  input  logic                       in_ready,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic        [ENV_W-1:0]    attack_rate,
  input  logic        [ENV_W-1:0]    decay_rate,
  input  logic        [ENV_W-1:0]    sustain_level,
  input  logic        [ENV_W-1:0]    release_rate,
`ifdef ADSR_VELOCITY_EN
  input  logic        [6:0]          velocity,
`endif
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       out_valid,
  output logic        [ENV_W-1:0]    env_level,
  output logic        [2:0]          env_state
);

  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_e;

  state_e                     state_q, state_d, ev_state;
  logic        [ENV_W-1:0]    level_q, level_d;
  logic                       gate_q;
  logic                       rise_pend_q, rise_pend_d;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic                       valid_q;

  logic                       rise_now, rise_evt;
  logic        [ENV_W-1:0]    peak, sus_t;
  logic        [ENV_W:0]      sum_a, dif_d, dif_r;
  logic signed [SAMPLE_W+ENV_W:0] prod;
  logic                       unused_ok;

  // A gate rise counts only if the gate is still high when the strobe arrives.
  // When a rise and a fall both occur between strobes, the final gate level decides.
  assign rise_now = gate & ~gate_q;
  assign rise_evt = (rise_pend_q | rise_now) & gate;
  assign rise_pend_d = in_ready ? 1'b0 : (rise_pend_q | rise_now);

`ifdef ADSR_VELOCITY_EN
  logic [6:0]       vel_q, vel_eff;
  logic [ENV_W+6:0] peak_x, sus_x;
  // A new velocity takes effect on the same strobe that applies its gate rise.
  assign vel_eff = (in_ready && rise_evt) ? velocity : vel_q;
  assign peak_x  = {7'd0, ENV_MAX} * {{ENV_W{1'b0}}, vel_eff};
  assign sus_x   = {7'd0, sustain_level} * {{ENV_W{1'b0}}, vel_eff};
  assign peak    = (vel_eff == 7'd127) ? ENV_MAX : peak_x[ENV_W+6:7];
  assign sus_t   = (vel_eff == 7'd127) ? sustain_level : sus_x[ENV_W+6:7];
  // Velocity latch, updated only by an applied rise.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vel_q <= 7'd127;
    else        vel_q <= vel_eff;
`else
  assign peak  = ENV_MAX;
  assign sus_t = sustain_level;
`endif

  // The sum and differences are one bit wider than the level, so clamping never wraps.
  assign sum_a = {1'b0, level_q} + {1'b0, attack_rate};
  assign dif_d = {1'b0, level_q} - {1'b0, decay_rate};
  assign dif_r = {1'b0, level_q} - {1'b0, release_rate};

  // Modulate by the level from before this strobe's update. Treat level 0 as a positive multiplier.
  assign prod = $signed({{(ENV_W+1){sample_in[SAMPLE_W-1]}}, sample_in})
              * $signed({{SAMPLE_W{1'b0}}, 1'b0, level_q});
  assign sample_d = (level_q == ENV_MAX) ? sample_in : prod[SAMPLE_W+ENV_W-1:ENV_W];
  assign unused_ok = ^{prod[SAMPLE_W+ENV_W], prod[ENV_W-1:0]};

  // Next state and level: apply any gate event first, then step the resulting stage.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    ev_state = state_q;
    if (in_ready) begin
      if (rise_evt)
        ev_state = ATTACK;
      else if (!gate && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN))
        ev_state = RELEASE;
      state_d = ev_state;
      case (ev_state)
        ATTACK: begin
          if (attack_rate == '0 || sum_a >= {1'b0, peak}) begin
            level_d = peak;
            state_d = DECAY;
          end else begin
            level_d = sum_a[ENV_W-1:0];
          end
        end
        DECAY: begin
          if (decay_rate == '0 || dif_d[ENV_W] || dif_d <= {1'b0, sus_t}) begin
            level_d = sus_t;
            state_d = SUSTAIN;
          end else begin
            level_d = dif_d[ENV_W-1:0];
          end
        end
        SUSTAIN: level_d = sus_t;
        RELEASE: begin
          if (release_rate == '0 || dif_r[ENV_W] || dif_r == '0) begin
            level_d = '0;
            state_d = IDLE;
          end else begin
            level_d = dif_r[ENV_W-1:0];
          end
        end
        default: level_d = level_q;
      endcase
    end
  end

  // State, level, gate history and registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      level_q     <= '0;
      gate_q      <= 1'b0;
      rise_pend_q <= 1'b0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      gate_q      <= gate;
      rise_pend_q <= rise_pend_d;
      valid_q     <= in_ready;
      if (in_ready) sample_q <= sample_d;
    end
  end

  assign sample_out = sample_q;
  assign out_valid  = valid_q;
  assign env_level  = level_q;
  assign env_state  = state_q;

endmodule
